// File: rtl/axi_mm_patchkr_pkg.sv
// Shared types for the AXI-MM pattern checker: FSM state encoding and the
// two-bit status codes driven on patchkr_out.
package axi_mm_patchkr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] STAT_BUSY    = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_FAIL    = 2'b10;
  localparam logic [1:0] STAT_PASS    = 2'b11;

endpackage

// File: rtl/axi_mm_chkr_fifo.sv
// Single-clock first-word-fall-through FIFO holding expected beats.
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers and flags only)
//   wr_en        push request; dropped while full
//   wr_data      pushed word
//   rd_en        pop request; ignored while empty
//   head_c       current head word (combinational memory read)
//   empty, full  registered occupancy flags
module axi_mm_chkr_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_c,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // Next pointers; flags are registered from them so they never lag a push/pop.
  always_comb begin
    wr_ok      = wr_en & ~full;
    rd_ok      = rd_en & ~empty;
    wr_ptr_nxt = wr_ok ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = rd_ok ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign head_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_mm_patchkr_mc.sv
// Multi-channel pattern checker: compares received AXI beats against an
// expected-data FIFO and reports pass/fail/timeout with per-channel detail.
// Ports:
//   rdclk, rst_n                  clock, async active-low reset
//   patchkr_en / cntuspatt_en     burst start pulse / continuous-mode level
//   patgen_cnt                    beats expected per burst
//   patgen_din, patgen_din_wr     expected-data push; chkr_fifo_full flags full
//   axist_valid/tready/rcv_data   monitored received stream
//   patchkr_out                   status (00 busy, 11 pass, 10 fail, 01 timeout)
//   err_count, rcv_count          mismatching / compared beats (saturating)
//   err_chnl_mask, first_err_beat sticky channel mask, index of first mismatch
//   ovf_err                       sticky push-while-full
module axi_mm_patchkr_mc
  import axi_mm_patchkr_pkg::*;
#(
  parameter int unsigned AXI_CHNL_NUM = 1,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned CNT_WIDTH    = 9,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                               rdclk,
  input  logic                               rst_n,
  input  logic                               patchkr_en,
  input  logic                               cntuspatt_en,
  input  logic [CNT_WIDTH-1:0]               patgen_cnt,
  input  logic [AXI_CHNL_NUM*DATA_WIDTH-1:0] patgen_din,
  input  logic                               patgen_din_wr,
  output logic                               chkr_fifo_full,
  input  logic                               axist_valid,
  input  logic                               axist_tready,
  input  logic [AXI_CHNL_NUM*DATA_WIDTH-1:0] axist_rcv_data,
  output logic [1:0]                         patchkr_out,
  output logic [CNT_WIDTH-1:0]               err_count,
  output logic [CNT_WIDTH-1:0]               rcv_count,
  output logic [AXI_CHNL_NUM-1:0]            err_chnl_mask,
  output logic [CNT_WIDTH-1:0]               first_err_beat,
  output logic                               ovf_err
);

  localparam int unsigned BUS_W = AXI_CHNL_NUM * DATA_WIDTH;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  state_t               state;
  logic                 mode_cont;
  logic                 cntuspatt_q;
  logic [CNT_WIDTH-1:0] cnt_lat;
  logic [TO_W-1:0]      idle_cnt;

  logic [BUS_W-1:0]        head_c;
  logic                    fifo_empty;
  logic                    accept;
  logic                    pop;
  logic                    start;
  logic                    burst_hit;
  logic                    cont_fall;
  logic                    timeout_hit;
  logic                    beat_miss;
  logic [AXI_CHNL_NUM-1:0] slice_miss;
  logic [CNT_WIDTH-1:0]    rcv_nxt;
  logic [CNT_WIDTH-1:0]    err_nxt;

  axi_mm_chkr_fifo #(
    .WIDTH (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (rdclk),
    .rst_n   (rst_n),
    .wr_en   (patgen_din_wr),
    .wr_data (patgen_din),
    .rd_en   (pop),
    .head_c  (head_c),
    .empty   (fifo_empty),
    .full    (chkr_fifo_full)
  );

  // Beat acceptance, per-channel compare and completion conditions.
  always_comb begin
    slice_miss  = '0;
    start       = (state != ST_RUN) && (patchkr_en || (cntuspatt_en && !cntuspatt_q));
    burst_hit   = (state == ST_RUN) && !mode_cont && (rcv_count == cnt_lat);
    cont_fall   = mode_cont && cntuspatt_q && !cntuspatt_en;
    // Once the burst count is reached the run is over; further beats are not taken.
    accept      = (state == ST_RUN) && axist_valid && axist_tready && !burst_hit;
    pop         = accept && !fifo_empty;
    for (int unsigned ch = 0; ch < AXI_CHNL_NUM; ch++) begin
      slice_miss[ch] = fifo_empty ||
                       (head_c[ch*DATA_WIDTH +: DATA_WIDTH] !=
                        axist_rcv_data[ch*DATA_WIDTH +: DATA_WIDTH]);
    end
    beat_miss   = |slice_miss;
    timeout_hit = !accept && (idle_cnt == TO_W'(TIMEOUT - 1));
    rcv_nxt     = rcv_count;
    err_nxt     = err_count;
    if (accept && (rcv_count != '1)) rcv_nxt = rcv_count + 1'b1;
    if (accept && beat_miss && (err_count != '1)) err_nxt = err_count + 1'b1;
  end

  // Checker FSM with registered status and counters.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mode_cont      <= 1'b0;
      cntuspatt_q    <= 1'b0;
      cnt_lat        <= '0;
      idle_cnt       <= '0;
      patchkr_out    <= STAT_BUSY;
      err_count      <= '0;
      rcv_count      <= '0;
      err_chnl_mask  <= '0;
      first_err_beat <= '0;
      ovf_err        <= 1'b0;
    end else begin
      cntuspatt_q <= cntuspatt_en;
      if (patgen_din_wr && chkr_fifo_full) ovf_err <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_RUN;
            // Burst wins when both start sources fire together.
            mode_cont      <= !patchkr_en;
            cnt_lat        <= patgen_cnt;
            idle_cnt       <= '0;
            patchkr_out    <= STAT_BUSY;
            err_count      <= '0;
            rcv_count      <= '0;
            err_chnl_mask  <= '0;
            first_err_beat <= '0;
          end
        end
        ST_RUN: begin
          rcv_count <= rcv_nxt;
          err_count <= err_nxt;
          if (accept && beat_miss) begin
            err_chnl_mask <= err_chnl_mask | slice_miss;
            if (err_count == '0) first_err_beat <= rcv_count;
          end
          idle_cnt <= accept ? '0 : idle_cnt + 1'b1;
          if (burst_hit || cont_fall) begin
            state       <= ST_DONE;
            patchkr_out <= (err_nxt == '0) ? STAT_PASS : STAT_FAIL;
          end else if (timeout_hit) begin
            state       <= ST_DONE;
            patchkr_out <= STAT_TIMEOUT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_mm_patchkr_mc.md
AXI_MM_PATCHKR_MC -- requirements
Module: axi_mm_patchkr_mc

Interface
REQ-001 SHALL have parameters: AXI_CHNL_NUM, default 1, channel count; DATA_WIDTH, default 64, bits per channel; FIFO_DEPTH, default 512, expected-FIFO entries (power of 2); CNT_WIDTH, default 9, beat/error counter width; TIMEOUT, default 1024, idle cycles before timeout.
REQ-002 SHALL have ports, in this order:
  rdclk  in  1  single clock;
  rst_n  in  1  asynchronous active-low reset;
  patchkr_en  in  1  burst-mode start pulse;
  cntuspatt_en  in  1  continuous-mode level;
  patgen_cnt  in  CNT_WIDTH  beats expected per burst;
  patgen_din  in  AXI_CHNL_NUM*DATA_WIDTH  expected data;
  patgen_din_wr  in  1  expected-data push;
  chkr_fifo_full  out  1  expected FIFO full;
  axist_valid  in  1  received-beat valid;
  axist_tready  in  1  received-beat ready (monitored only);
  axist_rcv_data  in  AXI_CHNL_NUM*DATA_WIDTH  received data;
  patchkr_out  out  2  status;
  err_count  out  CNT_WIDTH  mismatching beats;
  rcv_count  out  CNT_WIDTH  beats compared;
  err_chnl_mask  out  AXI_CHNL_NUM  sticky per-channel mismatch;
  first_err_beat  out  CNT_WIDTH  rcv_count value of first mismatch;
  ovf_err  out  1  sticky push-while-full.

Function
REQ-003 Beat accept SHALL be axist_valid & axist_tready in state RUN; beats outside RUN SHALL be ignored and SHALL NOT pop the FIFO.
REQ-004 Expected FIFO SHALL be first-word-fall-through; push on patgen_din_wr in any state; push while full SHALL be dropped and set ovf_err.
REQ-005 On accept with FIFO non-empty, head SHALL be popped and compared per channel slice; a beat mismatches if any slice differs.
REQ-006 On accept with FIFO empty, no pop; beat SHALL count as mismatch on all channels.
REQ-007 Accept in cycle N SHALL update rcv_count, err_count, err_chnl_mask, first_err_beat at N+1.
REQ-008 rcv_count and err_count SHALL saturate at all ones; first_err_beat SHALL capture only when err_count is 0.
REQ-009 FSM states IDLE, RUN, DONE; reset to IDLE.
REQ-010 IDLE/DONE -> RUN on patchkr_en=1 (burst) or cntuspatt_en rising edge (continuous); entry SHALL clear counters, err_chnl_mask, first_err_beat, patchkr_out to 00 and latch patgen_cnt.
REQ-011 Burst: RUN -> DONE the cycle after rcv_count equals latched patgen_cnt; patgen_cnt=0 SHALL reach DONE one cycle after entry.
REQ-012 Continuous: RUN -> DONE the cycle after cntuspatt_en falling edge; patgen_cnt ignored.
REQ-013 RUN -> DONE when TIMEOUT consecutive cycles pass with no accept.
REQ-014 patchkr_out SHALL be set on DONE entry: 11 pass (err_count 0), 10 fail, 01 timeout; held until next RUN entry.
REQ-015 Start requests in RUN SHALL be ignored; simultaneous patchkr_en and cntuspatt_en rise SHALL start burst mode.
REQ-016 FIFO contents SHALL persist across runs (no flush on start).

Reset
REQ-017 rst_n low SHALL asynchronously clear all state, FIFO pointers, and outputs to 0 (chkr_fifo_full 0, patchkr_out 00); deassertion mid-operation SHALL resume in IDLE.

Structure
REQ-018 Package axi_mm_patchkr_pkg SHALL hold FSM state enum and status constants (PASS 11, FAIL 10, TIMEOUT 01, BUSY 00).
REQ-019 Expected FIFO SHALL be sub-module axi_mm_chkr_fifo (single-clock FWFT, parameterised width/depth).

Verification
REQ-020 Push 8 beats 0..7, patgen_cnt=8, pulse patchkr_en, send 0..7 -> rcv_count 8, err_count 0, patchkr_out 11.
REQ-021 AXI_CHNL_NUM=2, beat 3 corrupts channel 1 -> err_count 1, err_chnl_mask 10, first_err_beat 3, patchkr_out 10.
REQ-022 patgen_cnt=4, send 2 beats then idle TIMEOUT cycles -> patchkr_out 01, rcv_count 2.
REQ-023 Continuous: rise cntuspatt_en, send 20 matching beats, fall -> patchkr_out 11 one cycle after fall detection, rcv_count 20.
REQ-024 Fill FIFO_DEPTH entries then push once more -> chkr_fifo_full 1, ovf_err 1; receive beat with FIFO empty -> err_count increments.
REQ-025 Assert rst_n low mid-RUN -> all outputs 0 immediately, FSM IDLE after release.
